// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared types and widths for the writeback port arbiter
package wb_port_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // x0 is hardwired to zero, so writes addressed to it carry no information
  function automatic logic rd_writable(input logic [REG_ADDR_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - small synchronous result queue with push/pop, full/empty and count
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                pop_entry,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign pop_entry = mem_q[rd_ptr_q];

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers are power-of-two wide, so plain increment wraps modulo DEPTH
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares the register-file write port between MEM/WB and the MDU; WB_BYPASS_EN enables direct MDU writes when idle
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wb_we,
  input  logic [REG_ADDR_W-1:0]         wb_rd,
  input  logic [DATA_W-1:0]             wb_data,
  input  logic                          mdu_valid,
  input  logic [REG_ADDR_W-1:0]         mdu_rd,
  input  logic [DATA_W-1:0]             mdu_data,
  output logic                          mdu_ready,
  output logic                          rf_we,
  output logic [REG_ADDR_W-1:0]         rf_rd,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic                          pipe_stall,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

  arb_state_e              state_q, state_d;
  logic [SW-1:0]           starve_q, starve_d;
  logic                    rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0]   rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0]       rf_wdata_q, rf_wdata_d;
  logic                    pipe_stall_q, pipe_stall_d;

  logic                    pipe_req;
  logic                    bypass;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  wb_entry_t               fifo_head;
  wb_entry_t               mdu_entry;

  assign pipe_req  = wb_we && rd_writable(wb_rd);
  assign mdu_ready = (fifo_count != CW'(FIFO_DEPTH));
  assign mdu_entry = '{rd: mdu_rd, data: mdu_data};

  // x0 results complete the handshake but are dropped; bypassed results skip the queue
  assign fifo_push = mdu_valid && mdu_ready && rd_writable(mdu_rd) && !bypass;

  wb_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (mdu_entry),
    .pop        (fifo_pop),
    .pop_entry  (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    fifo_pop   = 1'b0;
    bypass     = 1'b0;
    case (state_q)
      NORMAL: begin
        if (pipe_req) begin
          rf_we_d    = 1'b1;
          rf_rd_d    = wb_rd;
          rf_wdata_d = wb_data;
          if (fifo_empty) begin
            starve_d = '0;
          end else if (starve_q == SW'(STARVE_LIMIT - 1)) begin
            state_d  = FORCE;
            starve_d = '0;
          end else begin
            starve_d = starve_q + SW'(1);
          end
        end else if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          rf_we_d    = 1'b1;
          rf_rd_d    = fifo_head.rd;
          rf_wdata_d = fifo_head.data;
          starve_d   = '0;
        end else begin
          starve_d = '0;
`ifdef WB_BYPASS_EN
          if (mdu_valid && rd_writable(mdu_rd)) begin
            bypass     = 1'b1;
            rf_we_d    = 1'b1;
            rf_rd_d    = mdu_rd;
            rf_wdata_d = mdu_data;
          end
`endif
        end
      end
      FORCE: begin
        // FIFO cannot be empty here: entering FORCE required a queued entry
        fifo_pop   = 1'b1;
        rf_we_d    = 1'b1;
        rf_rd_d    = fifo_head.rd;
        rf_wdata_d = fifo_head.data;
        starve_d   = '0;
        state_d    = NORMAL;
      end
      default: begin
        state_d  = NORMAL;
        starve_d = '0;
      end
    endcase
    pipe_stall_d = (state_d == FORCE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= NORMAL;
      starve_q     <= '0;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_wdata_q   <= '0;
      pipe_stall_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_wdata_q   <= rf_wdata_d;
      pipe_stall_q <= pipe_stall_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_rd      = rf_rd_q;
  assign rf_wdata   = rf_wdata_q;
  assign pipe_stall = pipe_stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter (default build, WB_BYPASS_EN undefined)
module tb_wb_port_arbiter;

  logic        clock;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        pipe_stall;
  logic [1:0]  fifo_count;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  wb_port_arbiter #(
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .mdu_valid  (mdu_valid),
    .mdu_rd     (mdu_rd),
    .mdu_data   (mdu_data),
    .mdu_ready  (mdu_ready),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_wdata   (rf_wdata),
    .pipe_stall (pipe_stall),
    .fifo_count (fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    wb_we   = we;
    wb_rd   = rd;
    wb_data = data;
  endtask

  task automatic set_mdu(input logic v, input logic [4:0] rd, input logic [31:0] data);
    mdu_valid = v;
    mdu_rd    = rd;
    mdu_data  = data;
  endtask

  // Monitor: every register-file write must match the oldest expected write
  always @(negedge clock) begin
    if (!reset && rf_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write", rf_rd, rf_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_rd", {27'd0, rf_rd}, {27'd0, e.rd});
        check("sb_data", rf_wdata, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_wb(1'b0, 5'd0, 32'd0);
    set_mdu(1'b0, 5'd0, 32'd0);
    repeat (2) tick();
    check("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_pipe_stall", {31'd0, pipe_stall}, 32'd0);
    check("rst_fifo_count", {30'd0, fifo_count}, 32'd0);
    check("rst_mdu_ready", {31'd0, mdu_ready}, 32'd1);
    reset = 1'b0;
    tick();

    // MDU-only write: two-cycle latency through the queue
    set_mdu(1'b1, 5'd5, 32'h1234_5678);
    expect_write(5'd5, 32'h1234_5678);
    tick();
    set_mdu(1'b0, 5'd0, 32'd0);
    check("mdu_only_count1", {30'd0, fifo_count}, 32'd1);
    check("mdu_only_we_lat1", {31'd0, rf_we}, 32'd0);
    tick();
    check("mdu_only_we_lat2", {31'd0, rf_we}, 32'd1);
    check("mdu_only_count0", {30'd0, fifo_count}, 32'd0);
    tick();

    // Priority: pipe wins over a queued MDU result
    set_mdu(1'b1, 5'd7, 32'h0000_0077);
    tick();
    set_mdu(1'b0, 5'd0, 32'd0);
    set_wb(1'b1, 5'd3, 32'h0000_000A);
    expect_write(5'd3, 32'h0000_000A);
    expect_write(5'd7, 32'h0000_0077);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    check("prio_first_rd", {27'd0, rf_rd}, 32'd3);
    tick();
    check("prio_second_rd", {27'd0, rf_rd}, 32'd7);
    check("prio_count0", {30'd0, fifo_count}, 32'd0);
    tick();

    // Starvation: four pipe wins, one forced drain, then pipe resumes
    set_mdu(1'b1, 5'd7, 32'h0000_BEEF);
    tick();
    set_mdu(1'b0, 5'd0, 32'd0);
    set_wb(1'b1, 5'd9, 32'h0000_0099);
    for (int i = 0; i < 4; i++) expect_write(5'd9, 32'h0000_0099);
    expect_write(5'd7, 32'h0000_BEEF);
    expect_write(5'd9, 32'h0000_0099);
    repeat (3) tick();
    check("starve_no_stall_early", {31'd0, pipe_stall}, 32'd0);
    tick();
    check("starve_stall_on", {31'd0, pipe_stall}, 32'd1);
    tick();
    check("starve_stall_off", {31'd0, pipe_stall}, 32'd0);
    check("starve_forced_rd", {27'd0, rf_rd}, 32'd7);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    check("starve_resume_rd", {27'd0, rf_rd}, 32'd9);
    check("starve_count0", {30'd0, fifo_count}, 32'd0);
    tick();

    // Full FIFO: third result held until the cycle after the first pop
    set_wb(1'b1, 5'd4, 32'h0000_0044);
    set_mdu(1'b1, 5'd10, 32'h0000_00A0);
    for (int i = 0; i < 3; i++) expect_write(5'd4, 32'h0000_0044);
    expect_write(5'd10, 32'h0000_00A0);
    expect_write(5'd11, 32'h0000_00A1);
    expect_write(5'd12, 32'h0000_00A2);
    tick();
    set_mdu(1'b1, 5'd11, 32'h0000_00A1);
    tick();
    check("full_count2", {30'd0, fifo_count}, 32'd2);
    check("full_not_ready", {31'd0, mdu_ready}, 32'd0);
    set_mdu(1'b1, 5'd12, 32'h0000_00A2);
    tick();
    check("full_held_count", {30'd0, fifo_count}, 32'd2);
    set_wb(1'b0, 5'd0, 32'd0);
    tick();
    check("full_after_pop_count", {30'd0, fifo_count}, 32'd1);
    check("full_after_pop_ready", {31'd0, mdu_ready}, 32'd1);
    tick();
    set_mdu(1'b0, 5'd0, 32'd0);
    check("full_push_pop_count", {30'd0, fifo_count}, 32'd1);
    tick();
    check("full_drain_count", {30'd0, fifo_count}, 32'd0);
    tick();

    // rd=0 filtering on both paths
    set_wb(1'b1, 5'd0, 32'hDEAD_0000);
    tick();
    check("rd0_pipe_no_write", {31'd0, rf_we}, 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    set_mdu(1'b1, 5'd0, 32'hDEAD_0001);
    #1;
    check("rd0_mdu_ready", {31'd0, mdu_ready}, 32'd1);
    tick();
    set_mdu(1'b0, 5'd0, 32'd0);
    check("rd0_mdu_count", {30'd0, fifo_count}, 32'd0);
    tick();
    check("rd0_mdu_no_write", {31'd0, rf_we}, 32'd0);

    // Async reset during FORCE discards the queued entry
    set_mdu(1'b1, 5'd13, 32'h0000_000D);
    tick();
    set_mdu(1'b0, 5'd0, 32'd0);
    set_wb(1'b1, 5'd14, 32'h0000_000E);
    for (int i = 0; i < 3; i++) expect_write(5'd14, 32'h0000_000E);
    repeat (4) tick();
    check("arst_in_force", {31'd0, pipe_stall}, 32'd1);
    check("arst_pre_we", {31'd0, rf_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("arst_rf_we", {31'd0, rf_we}, 32'd0);
    check("arst_rf_rd", {27'd0, rf_rd}, 32'd0);
    check("arst_rf_wdata", rf_wdata, 32'd0);
    check("arst_stall", {31'd0, pipe_stall}, 32'd0);
    check("arst_count", {30'd0, fifo_count}, 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("arst_post_stall", {31'd0, pipe_stall}, 32'd0);
    set_mdu(1'b1, 5'd6, 32'h0000_0666);
    expect_write(5'd6, 32'h0000_0666);
    tick();
    set_mdu(1'b0, 5'd0, 32'd0);
    tick();
    check("arst_normal_rd", {27'd0, rf_rd}, 32'd6);
    check("arst_normal_stall", {31'd0, pipe_stall}, 32'd0);
    repeat (3) tick();

    check("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
